// File: rtl/nibble_add_seq.sv
// Sequential WIDTH-bit adder that reuses a single 4-bit adder, one nibble per clock.
// Optional subtract mode (input port sub) is enabled by defining NIBBLE_ADD_SEQ_SUB_EN.

module my_add (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    assign {co, s} = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
endmodule

module nibble_add_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef NIBBLE_ADD_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
);
    localparam int N  = WIDTH / 4;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [CW-1:0]    cnt;
    logic             last;
    logic [3:0]       add_s;
    logic             add_co;
    logic [WIDTH-1:0] b_in;
    logic             c_in;

    // Subtraction is a + ~b + 1; cin is ignored for a subtract request.
`ifdef NIBBLE_ADD_SEQ_SUB_EN
    assign b_in = sub ? ~b : b;
    assign c_in = sub ? 1'b1 : cin;
`else
    assign b_in = b;
    assign c_in = cin;
`endif

    assign last = (cnt == CW'(N - 1));

    my_add u_add (
        .a  (a_q[4*cnt +: 4]),
        .b  (b_q[4*cnt +: 4]),
        .ci (carry_q),
        .s  (add_s),
        .co (add_co)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b_in;
                        carry_q <= c_in;
                        cnt     <= '0;
                    end
                end
                RUN: begin
                    // The top nibble's carry goes only to cout; the next start reloads carry_q.
                    sum[4*cnt +: 4] <= add_s;
                    carry_q         <= add_co;
                    cnt             <= cnt + 1'b1;
                    if (last) cout <= add_co;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
endmodule

// File: tb/tb_nibble_add_seq.sv
// Scoreboard bench for nibble_add_seq (WIDTH=16): directed vectors push {cout,sum}
// and the expected done cycle; a monitor pops and compares on every done pulse.

module tb_nibble_add_seq;
    localparam int WIDTH = 16;
    localparam int N     = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic             sub_tb = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
    logic             done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [WIDTH:0] exp_q[$];
    int             exp_cyc_q[$];

    nibble_add_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef NIBBLE_ADD_SEQ_SUB_EN
        .sub   (sub_tb),
`endif
        .sum   (sum),
        .cout  (cout),
        .busy  (busy),
        .done  (done)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_done: got done=1 expected no pending result (cycle %0d)", cyc);
            end else begin
                logic [WIDTH:0] e;
                int             ec;
                e  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                check("result", {47'd0, cout, sum}, {47'd0, e});
                check("done_cycle", 64'(cyc), 64'(ec));
            end
        end
    end

    // driver: call on a negedge; returns on the negedge after the accepting edge
    task automatic issue(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic cv,
                         input logic sv, input logic [WIDTH-1:0] es, input logic ec);
        a      = av;
        b      = bv;
        cin    = cv;
        sub_tb = sv;
        start  = 1'b1;
        exp_q.push_back({ec, es});
        exp_cyc_q.push_back(cyc + 1 + N);
        @(negedge clk);
        start = 1'b0;
        a     = 16'($urandom);
        b     = 16'($urandom);
        cin   = 1'($urandom);
    endtask

    task automatic wait_idle(input string name, output int busy_cycles);
        int n;
        busy_cycles = 0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            busy_cycles++;
            n++;
            @(negedge clk);
        end
        if (busy !== 1'b0) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got busy=%b expected 0 within 40 cycles", name, busy);
        end
        @(negedge clk);
    endtask

    initial begin
        int bc;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sum", 64'(sum), 64'h0);
        check("rst_cout", 64'(cout), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_done", 64'(done), 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // basic add, latency and busy width
        issue(16'h0001, 16'h000A, 1'b0, 1'b0, 16'h000B, 1'b0);
        wait_idle("t1", bc);
        check("busy_cycles", 64'(bc), 64'd5);

        // full ripple, per-nibble carries, no wrap of top carry into nibble 0
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
        wait_idle("t2a", bc);
        issue(16'h7777, 16'h9999, 1'b1, 1'b0, 16'h1111, 1'b1);
        wait_idle("t2b", bc);
        issue(16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0);
        wait_idle("t2c", bc);
        issue(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1);
        wait_idle("t2d", bc);

        // start pulsed during RUN with different operands is ignored
        issue(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0);
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("t3", bc);
        repeat (8) @(negedge clk);

        // reset in the third RUN cycle aborts with no done pulse
        issue(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0);
        void'(exp_q.pop_back());
        void'(exp_cyc_q.pop_back());
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'h0);
        check("abort_sum", 64'(sum), 64'h0);
        check("abort_cout", 64'(cout), 64'h0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // start held high: back-to-back every N+2 cycles
        a = 16'h1234; b = 16'h4321; cin = 1'b0; sub_tb = 1'b0;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back({1'b0, 16'h5555});
            exp_cyc_q.push_back(cyc + 1 + N + k * (N + 2));
        end
        start = 1'b1;
        repeat (14) @(negedge clk);
        start = 1'b0;
        wait_idle("t5", bc);

`ifdef NIBBLE_ADD_SEQ_SUB_EN
        issue(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0);
        wait_idle("t6a", bc);
        issue(16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1);
        wait_idle("t6b", bc);
`endif

        repeat (4) @(negedge clk);
        check("pending_results", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/nibble_add_seq.md
NIBBLE_ADD_SEQ -- requirements
Module: nibble_add_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, operand width in bits; legal values are multiples of 4 in the range 8 to 64.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-004 The block SHALL have port start, input, 1, request to begin one addition.
REQ-005 The block SHALL have port a, input, WIDTH, operand A.
REQ-006 The block SHALL have port b, input, WIDTH, operand B.
REQ-007 The block SHALL have port cin, input, 1, carry into nibble 0.
REQ-008 The block SHALL have port sum, output, WIDTH, registered result.
REQ-009 The block SHALL have port cout, output, 1, registered carry out of the top nibble.
REQ-010 The block SHALL have port busy, output, 1, high while an operation is in progress.
REQ-011 The block SHALL have port done, output, 1, one-cycle pulse marking sum/cout valid.

Function
REQ-012 The block SHALL compute {cout,sum} = a + b + cin, using one instance of the team's 4-bit adder (my_add: a, b, ci, s, co), one nibble per cycle.
REQ-013 The FSM SHALL have the states IDLE, RUN and DONE; no other states are reachable.
REQ-014 IDLE: on start=1, the block SHALL latch a, b and cin into internal registers, clear the nibble counter to 0, and go to RUN; start=0 keeps the FSM in IDLE.
REQ-015 RUN: each cycle, the block SHALL feed nibble k of the latched A/B plus the carry register to the adder, write s into sum[4k+3:4k], and register co as the next carry.
REQ-016 After nibble N-1 (N=WIDTH/4), the block SHALL load the final co into cout and go to DONE.
REQ-017 DONE: the block SHALL assert done for exactly one cycle and then return to IDLE unconditionally.
REQ-018 Latency: for start sampled high at edge 0, done SHALL be high during cycle N+1 (5 cycles for WIDTH=16).
REQ-019 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-020 start SHALL be ignored while busy=1; a, b and cin changing during RUN SHALL NOT affect the result.
REQ-021 start held high across DONE SHALL be accepted in the following IDLE cycle, giving back-to-back operations every N+2 cycles.
REQ-022 sum and cout SHALL hold their last result from DONE until the next accepted start; nibbles of sum update progressively during RUN and are valid only when done=1.
REQ-023 Carry wrap-around: the carry out of nibble N-1 SHALL NOT feed back into nibble 0; it goes to cout only.

Reset
REQ-024 While rst_n=0 at a clock edge, the block SHALL enter IDLE with sum=0, cout=0, busy=0, done=0, carry register=0 and counter=0.
REQ-025 Reset asserted mid-RUN or in DONE SHALL abort the operation with no done pulse; reset SHALL override a simultaneous start.

Configuration
REQ-026 The block SHALL have macro NIBBLE_ADD_SEQ_SUB_EN; when it is defined, the block SHALL add a 1-bit input port sub.
REQ-027 With NIBBLE_ADD_SEQ_SUB_EN defined, when start is accepted with sub=1 the block SHALL latch ~b and force the initial carry to 1, computing a - b, with cout=1 meaning no borrow; the cin port is ignored in that case.
REQ-028 Without NIBBLE_ADD_SEQ_SUB_EN, there SHALL be no sub port and the block SHALL perform addition only.

Verification (WIDTH=16)
REQ-029 Test: a=16'h0001, b=16'h000A, cin=0, one-cycle start -> sum=16'h000B, cout=0, done pulse exactly 5 cycles after start, busy high for 5 cycles.
REQ-030 Test: a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, cout=1 (carry ripples through all 4 nibbles); also a=16'h7777, b=16'h9999, cin=1 -> sum=16'h1111, cout=1.
REQ-031 Test: start pulsed again 2 cycles into RUN with different operands -> pulse ignored, first result unchanged, exactly one done pulse.
REQ-032 Test: rst_n driven low in cycle 3 of RUN -> next cycle busy=0, sum=0, cout=0, and no done pulse follows.
REQ-033 Test: start held high continuously with fixed operands a=16'h1234, b=16'h4321 -> done every 6 cycles, sum=16'h5555 each time.
REQ-034 Test: with NIBBLE_ADD_SEQ_SUB_EN defined, sub=1, a=16'h0005, b=16'h0007 -> sum=16'hFFFE, cout=0; with a=16'h0007, b=16'h0005 -> sum=16'h0002, cout=1.
